// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  // Width of the bit counter for a given operand width.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// Combinational 1-bit full subtractor cell (a - b - bin).
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of a single bit position.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: d = a - b, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);

  sub_state_t     state;
  sub_state_t     state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic           br;
  logic [CW-1:0]  cnt;
  logic           diff;
  logic           br_next;
  logic           last;
`ifdef SERIAL_SUB_OVF_EN
  logic           a_msb;
  logic           b_msb;
`endif

  full_sub u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (diff),
    .bout (br_next)
  );

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand shifting, borrow chain, counter and result capture.
  // SA doubles as the result register: each consumed minuend bit frees its
  // MSB slot for the new difference bit, so after WIDTH shifts it holds d.
  always_ff @(posedge clk) begin
    if (reset) begin
      sa    <= '0;
      sb    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          sa <= {diff, sa[WIDTH-1:1]};
          sb <= {1'b0, sb[WIDTH-1:1]};
          br <= br_next;
          if (last) begin
            d    <= {diff, sa[WIDTH-1:1]};
            bout <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= (a_msb != b_msb) && (diff != a_msb);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4); covers the optional
// ovf output when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles since the accepting edge, and the operands captured there.
  int age = -1;
  int pa = 0;
  int pb = 0;
  int exp_d = 0;
  bit exp_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
  bit exp_ovf = 1'b0;
`endif

  always @(posedge clk) begin
    if (reset) begin
      age = -1; exp_d = 0; exp_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      exp_ovf = 1'b0;
`endif
    end else if (age < 0) begin
      if (start) begin
        age = 0; pa = int'(a); pb = int'(b);
      end
    end else begin
      age++;
      if (age == W) begin
        exp_d    = (pa - pb) & MASK;
        exp_bout = (pa < pb);
`ifdef SERIAL_SUB_OVF_EN
        begin
          int sa_s, sb_s, r;
          sa_s = (pa >= (1 << (W - 1))) ? pa - (1 << W) : pa;
          sb_s = (pb >= (1 << (W - 1))) ? pb - (1 << W) : pb;
          r = sa_s - sb_s;
          exp_ovf = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
        end
`endif
      end else if (age > W) begin
        age = -1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    if (check_en) begin
      chk("busy", busy, (age >= 0));
      chk("done", done, (age == W));
      chk("d",    d,    exp_d);
      chk("bout", bout, exp_bout);
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf",  ovf,  exp_ovf);
`endif
    end
  end

  // Issue one operation with random noise on a/b afterwards; return result and latency.
  task automatic run_op(input int x, input int y, output int got_d, output int got_bout, output int lat);
    int n;
    @(negedge clk);
    start = 1'b1; a = W'(x); b = W'(y);
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      n++;
    end
    got_d = int'(d);
    got_bout = int'(bout);
    lat = n;
  endtask

  initial begin
    int gd, gb, lat, nd;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_d", d, 0);
    reset = 1'b0;

    // Basic cases with hand-computed results.
    run_op(9, 3, gd, gb, lat);
    chk("lat_9_3", lat, W + 1);
    chk("d_9_3", gd, 6);
    chk("bout_9_3", gb, 0);
    chk("model_d_9_3", exp_d, 6);
    run_op(3, 9, gd, gb, lat);
    chk("d_3_9", gd, 4'b1010);
    chk("bout_3_9", gb, 1);
    chk("model_bout_3_9", exp_bout, 1);
    run_op(0, 15, gd, gb, lat);
    chk("d_0_15", gd, 1);
    chk("bout_0_15", gb, 1);
    run_op(15, 15, gd, gb, lat);
    chk("d_15_15", gd, 0);
    chk("bout_15_15", gb, 0);

    // start held high with a/b changing every cycle: one op per W+2 cycles.
    @(negedge clk);
    start = 1'b1; a = W'($urandom); b = W'($urandom);
    nd = 0;
    for (int i = 0; i < 3 * (W + 2); i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      if (done) nd++;
    end
    start = 1'b0;
    chk("held_start_dones", nd, 3);

    // Reset during RUN at count=2 abandons the operation.
    @(negedge clk);
    start = 1'b1; a = 4'd12; b = 4'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_d", d, 0);
    chk("midrst_bout", bout, 0);
    reset = 1'b0;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_no_done", nd, 0);
    run_op(12, 5, gd, gb, lat);
    chk("post_rst_d", gd, 7);
    chk("post_rst_lat", lat, W + 1);

`ifdef SERIAL_SUB_OVF_EN
    run_op(7, 8, gd, gb, lat);
    chk("d_7_8", gd, 15);
    chk("ovf_7_8", ovf, 1);
    run_op(8, 1, gd, gb, lat);
    chk("d_8_1", gd, 7);
    chk("ovf_8_1", ovf, 1);
    run_op(5, 2, gd, gb, lat);
    chk("d_5_2", gd, 3);
    chk("ovf_5_2", ovf, 0);
`endif

    // Exhaustive sweep of all operand pairs.
    for (int i = 0; i < 256; i++) begin
      run_op(i / 16, i % 16, gd, gb, lat);
      chk("sweep_d", gd, ((i / 16) - (i % 16)) & MASK);
      chk("sweep_bout", gb, ((i / 16) < (i % 16)) ? 1 : 0);
    end

    // Random operations with random idle gaps (d must hold between them).
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), gd, gb, lat);
      chk("rand_lat", lat, W + 1);
    end

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor that computes D = A - B, one bit per clock, LSB first, with a borrow chain held in a flip-flop. It is the inverse-operation counterpart to the team's combinational ripple-carry adder. It sits beside that adder in the lab datapath and trades latency for a single subtractor cell. A start/busy/done handshake lets a controller issue an operation and collect the result.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a new subtraction; sampled only in IDLE.
a  input  WIDTH  minuend; latched on the edge that accepts start.
b  input  WIDTH  subtrahend; latched on the edge that accepts start.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; d/bout valid.
d  output  WIDTH  difference A - B modulo 2^WIDTH.
bout  output  1  final borrow; 1 iff A < B (unsigned).

Behaviour:
- Reset, checked on the rising edge and taking priority over everything else:
  - state=IDLE; busy=0, done=0, d=0, bout=0.
  - Internal shift registers, borrow flop and bit counter cleared.
  - A reset mid-operation abandons the operation with no done pulse.
- IDLE:
  - If start=1, latch a into shift register SA and b into SB, clear borrow, set count=0, and go to RUN.
  - If start=0, stay in IDLE.
- RUN, one bit per edge:
  - diff bit = SA[0] ^ SB[0] ^ br.
  - br_next = (~SA[0] & SB[0]) | (~(SA[0] ^ SB[0]) & br).
  - SA and SB shift right by 1; the diff bit shifts into the MSB of the result register.
  - count increments each edge.
  - On the edge processing bit WIDTH-1, go to DONE and register bout = br_next.
- DONE:
  - done=1 for exactly one cycle; d holds the full result.
  - Next edge returns to IDLE.
- Latency: if start is accepted at edge k, done is high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- Handshake rules:
  - start is ignored in RUN and DONE; no queuing.
  - a and b may change freely after acceptance.
- Output hold: d and bout hold their last result until the next DONE or reset. They are not cleared by a new start.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - a == b gives d=0, bout=0.
  - a=0, b=max gives d=1, bout=1.
- Counter width is $clog2(WIDTH). It never wraps because the transition to DONE occurs at count=WIDTH-1.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), which is signed two's-complement overflow of A - B: (a_msb != b_msb) && (d_msb != a_msb).
  - ovf is registered with d on the DONE transition, reset to 0, and held like d.
  - Original MSBs of a and b are saved at acceptance.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t.
  - localparam function cnt_w(width) returning $clog2(width).
- Sub-module full_sub: combinational 1-bit full subtractor (a, b, bin -> d, bout), instantiated once in the datapath. It mirrors the team's full-adder cell.

Test Plan:
- Reset, then start with a=9, b=3 (WIDTH=4) -> done pulses 4 cycles after the accept edge (+1), d=6, bout=0, busy high for 5 cycles.
- a=3, b=9 -> d=4'b1010, bout=1. a=0, b=15 -> d=1, bout=1. a=15, b=15 -> d=0, bout=0.
- Hold start high for the whole run, with a/b changing each cycle -> exactly one done per WIDTH+2 cycles, each using the values present at the accept edge; mid-run changes have no effect.
- Assert reset at RUN count=2 -> next cycle busy=0, done=0, d=0, bout=0; no done pulse follows; a new start works normally.
- Exhaustive 4-bit sweep (256 pairs), compared against (a-b) mod 16 and a<b -> zero mismatches; d holds between operations.
- With SERIAL_SUB_OVF_EN: a=7, b=8 -> d=15, ovf=1; a=8, b=1 -> d=7, ovf=1; a=5, b=2 -> ovf=0.
